// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_ctrl
//  Purpose  : Single-port data memory for the load/store unit. A request
//             channel (valid/ready) carries one read or write, and a response
//             channel (valid/ready) returns read data and an error flag for
//             misaligned or out-of-range addresses. Only one transaction is
//             in flight at a time; peak throughput is one per three cycles.
//  Ports    : clk, rst (async, active-high)
//             req_valid/req_ready, req_write, req_addr, req_wdata, req_be
//             resp_valid/resp_ready, resp_rdata, resp_err
//  Options  : DMEM_BYTE_WRITE_EN - when defined, req_be selects the bytes
//             written; otherwise every good write replaces the whole word.
//  Revision : 1.0 - initial release
// ============================================================================
module data_memory_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err
);

    localparam int NB     = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(NB);
    localparam int IDX_W  = ADDR_WIDTH - OFFS;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Comparison width wide enough for both the word index and DEPTH.
    localparam int CMP_W  = (IDX_W > 32) ? IDX_W + 1 : 33;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_idle_ready;

    logic                    r_write;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [NB-1:0]           r_be;

    logic                    r_resp_valid;
    logic [DATA_WIDTH-1:0]   r_resp_rdata;
    logic                    r_resp_err;

    logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];

    logic [IDX_W-1:0]        w_idx;
    logic [MEM_AW-1:0]       w_mem_idx;
    logic                    w_misalign;
    logic                    w_oor;
    logic                    w_err;
    logic                    w_mem_we;
    logic [NB-1:0]           w_mask;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_idle_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_idle_ready = 1'b1;
                if (req_valid) w_next = ST_ACCESS;
            end
            ST_ACCESS: w_next = ST_RESP;
            ST_RESP:   if (resp_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Ready is forced low for as long as reset is held.
    assign req_ready = w_idle_ready & ~rst;

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (req_valid && req_ready) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    // ------------------------------------------------------------------
    // Address decode and error detection
    // ------------------------------------------------------------------
    assign w_idx     = r_addr[ADDR_WIDTH-1:OFFS];
    assign w_mem_idx = w_idx[MEM_AW-1:0];

    generate
        if (OFFS > 0) begin : g_align_check
            assign w_misalign = |r_addr[OFFS-1:0];
        end else begin : g_no_align_check
            // Byte-wide words can never be misaligned.
            assign w_misalign = 1'b0;
        end
    endgenerate

    assign w_oor = (CMP_W'(w_idx) >= CMP_W'(DEPTH));
    assign w_err = w_misalign | w_oor;

`ifdef DMEM_BYTE_WRITE_EN
    assign w_mask = r_be;
`else
    logic w_unused_be;
    assign w_unused_be = ^r_be;
    assign w_mask      = '1;
`endif

    // The array has no reset, so gate on rst explicitly: a reset that lands
    // while a write is in ACCESS must not let the write commit.
    assign w_mem_we = (r_state == ST_ACCESS) && !rst && r_write && !w_err;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (w_mask[b]) begin
                    r_mem[w_mem_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else if (r_state == ST_ACCESS) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_err;
            // Writes and faulting accesses return zero data.
            r_resp_rdata <= (!w_err && !r_write) ? r_mem[w_mem_idx] : '0;
        end else if ((r_state == ST_RESP) && resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_memory_ctrl
//  Purpose  : Scoreboard bench for data_memory_ctrl. Instance A uses the
//             default 32-bit / 256-word configuration, instance B a 64-bit /
//             16-word one. Stimulus pushes expected responses into per-
//             instance queues; monitors pop them on each response handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_ctrl;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: 32-bit words, 256 deep
    logic        a_req_valid = 1'b0, a_req_ready, a_req_write = 1'b0;
    logic [31:0] a_req_addr = '0, a_req_wdata = '0;
    logic [3:0]  a_req_be = '0;
    logic        a_resp_valid, a_resp_ready = 1'b1, a_resp_err;
    logic [31:0] a_resp_rdata;

    // Instance B: 64-bit words, 16 deep
    logic        b_req_valid = 1'b0, b_req_ready, b_req_write = 1'b0;
    logic [31:0] b_req_addr = '0;
    logic [63:0] b_req_wdata = '0;
    logic [7:0]  b_req_be = '0;
    logic        b_resp_valid, b_resp_ready = 1'b1, b_resp_err;
    logic [63:0] b_resp_rdata;

    data_memory_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    data_memory_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(16)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst && a_resp_valid && a_resp_ready) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_resp", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("a_rdata", {32'd0, a_resp_rdata}, e.rdata);
                chk("a_err", {63'd0, a_resp_err}, {63'd0, e.err});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_resp_valid && b_resp_ready) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_resp", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk("b_rdata", b_resp_rdata, e.rdata);
                chk("b_err", {63'd0, b_resp_err}, {63'd0, e.err});
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    // Called #1 after a rising edge; returns #1 after edge k+2 (k = accept).
    task automatic txn_a(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e);
        exp_t e;
        int   n = 0;
        a_req_write = w; a_req_addr = addr; a_req_wdata = wd; a_req_be = be;
        a_req_valid = 1'b1;
        while (!a_req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!a_req_ready) begin
            chk("a_ready_timeout", 64'd0, 64'd1);
            a_req_valid = 1'b0;
            return;
        end
        e.rdata = {32'd0, exp_d};
        e.err   = exp_e;
        q_a.push_back(e);
        @(posedge clk); #1;                  // edge k
        a_req_valid = 1'b0;
        chk("a_valid_after_k", {63'd0, a_resp_valid}, 64'd0);
        @(posedge clk); #1;                  // edge k+1
        chk("a_valid_after_k1", {63'd0, a_resp_valid}, 64'd1);
        @(posedge clk); #1;                  // edge k+2
    endtask

    task automatic txn_b(input logic w, input logic [31:0] addr, input logic [63:0] wd,
                         input logic [7:0] be, input logic [63:0] exp_d, input logic exp_e);
        exp_t e;
        int   n = 0;
        b_req_write = w; b_req_addr = addr; b_req_wdata = wd; b_req_be = be;
        b_req_valid = 1'b1;
        while (!b_req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!b_req_ready) begin
            chk("b_ready_timeout", 64'd0, 64'd1);
            b_req_valid = 1'b0;
            return;
        end
        e.rdata = exp_d;
        e.err   = exp_e;
        q_b.push_back(e);
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- main sequence ----------------
    logic [31:0] exp_10;
    logic [31:0] exp_00;

    initial begin
`ifdef DMEM_BYTE_WRITE_EN
        exp_10 = 32'hDE22BE44;
        exp_00 = 32'h01234567;   // be = 0 write leaves the word alone
`else
        exp_10 = 32'h11223344;
        exp_00 = 32'hFFFFFFFF;   // strobes ignored: full word replaced
`endif
        // Reset values
        #1;
        chk("rst_req_ready", {63'd0, a_req_ready}, 64'd0);
        chk("rst_resp_valid", {63'd0, a_resp_valid}, 64'd0);
        chk("rst_resp_rdata", {32'd0, a_resp_rdata}, 64'd0);
        chk("rst_resp_err", {63'd0, a_resp_err}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_held_req_ready", {63'd0, a_req_ready}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_req_ready", {63'd0, a_req_ready}, 64'd1);

        // Basic write/read
        txn_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        txn_a(1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
        // Strobed write
        txn_a(1'b1, 32'h10, 32'h11223344, 4'h5, 32'h0, 1'b0);
        txn_a(1'b0, 32'h10, 32'h0,        4'h0, exp_10, 1'b0);
        // Errors leave the array untouched
        txn_a(1'b1, 32'h00, 32'h01234567, 4'hF, 32'h0, 1'b0);
        txn_a(1'b0, 32'h12, 32'h0,        4'h0, 32'h0, 1'b1);
        txn_a(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        txn_a(1'b0, 32'h00, 32'h0,        4'h0, 32'h01234567, 1'b0);
        // Zero-strobe write
        txn_a(1'b1, 32'h00, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
        txn_a(1'b0, 32'h00, 32'h0,        4'h0, exp_00, 1'b0);

        // Back-pressure: response held for 5 cycles
        a_resp_ready = 1'b0;
        txn_a(1'b0, 32'h10, 32'h0, 4'h0, exp_10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_resp_valid", {63'd0, a_resp_valid}, 64'd1);
            chk("hold_resp_rdata", {32'd0, a_resp_rdata}, {32'd0, exp_10});
            chk("hold_resp_err", {63'd0, a_resp_err}, 64'd0);
            chk("hold_req_ready", {63'd0, a_req_ready}, 64'd0);
            @(posedge clk); #1;
        end
        a_resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_req_ready", {63'd0, a_req_ready}, 64'd1);
        chk("release_resp_valid", {63'd0, a_resp_valid}, 64'd0);

        // Reset during ACCESS drops the write
        txn_a(1'b1, 32'h20, 32'h00000000, 4'hF, 32'h0, 1'b0);
        a_req_write = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'hCAFEF00D; a_req_be = 4'hF;
        a_req_valid = 1'b1;
        @(posedge clk); #1;                  // accepted, now in ACCESS
        a_req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_resp_valid", {63'd0, a_resp_valid}, 64'd0);
        chk("midrst_req_ready", {63'd0, a_req_ready}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("postrst_resp_valid", {63'd0, a_resp_valid}, 64'd0);
        end
        txn_a(1'b0, 32'h20, 32'h0, 4'h0, 32'h00000000, 1'b0);

        // 64-bit / 16-deep instance
        txn_b(1'b1, 32'h78, 64'h0, 8'hFF, 64'h0, 1'b0);
        txn_b(1'b1, 32'h78, 64'hAB00000000000000, 8'h80, 64'h0, 1'b0);
        txn_b(1'b0, 32'h78, 64'h0, 8'h00, 64'hAB00000000000000, 1'b0);
        txn_b(1'b0, 32'h80, 64'h0, 8'h00, 64'h0, 1'b1);
        txn_b(1'b0, 32'h7C, 64'h0, 8'h00, 64'h0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("q_a_drained", 64'(q_a.size()), 64'd0);
        chk("q_b_drained", 64'(q_b.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
